// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit with HI/LO result registers.
// Multiply uses shift-add on operand magnitudes, one bit per cycle. Divide uses
// restoring division, one quotient bit per cycle. Sign fixup and the HI/LO commit
// both happen in the cycle that leaves MUL/DIV for FIN.
// Build option: define MULDIV_DIV_EN to include the divider; without it, a divide
// request goes straight to FIN and leaves HI/LO untouched.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mt_hi,
    input  logic        mt_lo,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_commit;
    logic            r_busy;
    logic            r_done;
    logic [CW-1:0]   r_cnt;
    logic [2*W-1:0]  r_acc;
    logic [W-1:0]    r_dvs;
    logic            r_neg;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;

    logic            w_sgn;
    logic [W-1:0]    w_a_mag;
    logic [W-1:0]    w_b_mag;
    logic [W:0]      w_add;
    logic [2*W-1:0]  w_step_mul;
    logic            w_cnt_last;

`ifdef MULDIV_DIV_EN
    logic            r_rneg;
    logic            r_dz;
    logic [W:0]      w_rem_sh;
    logic [W:0]      w_sub;
    logic            w_ge;
    logic [2*W-1:0]  w_step_div;
`endif

    assign busy = r_busy;
    assign done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

    // Operand magnitudes and one shift-add step of the multiplier.
    always_comb begin
        w_sgn      = ~op[0];
        w_a_mag    = (w_sgn && A[W-1]) ? (-A) : A;
        w_b_mag    = (w_sgn && B[W-1]) ? (-B) : B;
        w_add      = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_dvs};
        w_step_mul = r_acc[0] ? {w_add, r_acc[W-1:1]} : {1'b0, r_acc[2*W-1:1]};
        w_cnt_last = (r_cnt == CW'(W));
    end

`ifdef MULDIV_DIV_EN
    // One restoring-division step: remainder in the upper half, quotient shifts into the lower half.
    always_comb begin
        w_rem_sh   = {r_acc[2*W-1:W], r_acc[W-1]};
        w_sub      = w_rem_sh - {1'b0, r_dvs};
        w_ge       = (w_rem_sh >= {1'b0, r_dvs});
        w_step_div = {(w_ge ? w_sub[W-1:0] : w_rem_sh[W-1:0]), r_acc[W-2:0], w_ge};
    end
`endif

    // State register plus registered busy/done decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == FIN);
        end
    end

    // Next-state logic; commit marks the final cycle of an iterative operation.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (!op[1]) begin
                        w_state_nxt = MUL;
                    end else begin
`ifdef MULDIV_DIV_EN
                        w_state_nxt = DIV;
`else
                        w_state_nxt = FIN;
`endif
                    end
                end
            end
            MUL, DIV: begin
                if (w_cnt_last) begin
                    w_state_nxt = FIN;
                    w_commit    = 1'b1;
                end
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, result commit and MTHI/MTLO writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_dvs  <= '0;
            r_neg  <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
`ifdef MULDIV_DIV_EN
            r_rneg <= 1'b0;
            r_dz   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt <= '0;
                        r_neg <= w_sgn & (A[W-1] ^ B[W-1]);
                        if (!op[1]) begin
                            r_acc <= {{W{1'b0}}, w_b_mag};
                            r_dvs <= w_a_mag;
                        end
`ifdef MULDIV_DIV_EN
                        else begin
                            r_acc <= {{W{1'b0}}, w_a_mag};
                            r_dvs <= w_b_mag;
                        end
                        r_rneg <= w_sgn & A[W-1];
                        r_dz   <= (B == '0);
`endif
                    end else begin
                        if (mt_hi) r_hi <= A;
                        if (mt_lo) r_lo <= A;
                    end
                end
                MUL: begin
                    if (w_commit) begin
                        {r_hi, r_lo} <= r_neg ? (-r_acc) : r_acc;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        r_acc <= w_step_mul;
                    end
                end
`ifdef MULDIV_DIV_EN
                DIV: begin
                    if (w_commit) begin
                        // Divide by zero leaves all-ones quotient; the remainder
                        // naturally equals |A| and the sign fixup restores A.
                        r_lo <= r_dz ? {W{1'b1}} :
                                (r_neg ? (-r_acc[W-1:0]) : r_acc[W-1:0]);
                        r_hi <= r_rneg ? (-r_acc[2*W-1:W]) : r_acc[2*W-1:W];
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        r_acc <= w_step_div;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit; divide vectors are selected by MULDIV_DIV_EN.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mt_hi;
    logic        mt_lo;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_chk;
    int n_err;
    logic [31:0] e_hi;
    logic [31:0] e_lo;

    muldiv_unit u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .mt_hi (mt_hi),
        .mt_lo (mt_lo),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if observed differs from expected.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Run one 33-cycle operation; also probes hold-during-busy and ignored mt writes.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] xhi, input logic [31:0] xlo);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        mt_hi = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mt_hi = 1'b0;
        op    = ~o;
        A     = 32'hDEAD_BEEF;
        B     = 32'h0000_0005;
        for (int i = 1; i <= 34; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                chk({tag, "_hold_hi"}, 64'(HI), 64'(e_hi));
                chk({tag, "_busy"}, 64'(busy), 64'd1);
            end
            if (i == 5) begin
                mt_lo = 1'b1;
                A     = 32'h0BAD_0BAD;
            end
            if (i == 6) mt_lo = 1'b0;
            if (i == 10) chk({tag, "_hold_lo"}, 64'(LO), 64'(e_lo));
            if (i == 32) chk({tag, "_done_early"}, 64'(done), 64'd0);
            if (i == 33) begin
                chk({tag, "_done"}, 64'(done), 64'd1);
                chk({tag, "_busy_fin"}, 64'(busy), 64'd1);
                chk({tag, "_hi"}, 64'(HI), 64'(xhi));
                chk({tag, "_lo"}, 64'(LO), 64'(xlo));
            end
            if (i == 34) begin
                chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
                chk({tag, "_idle_done"}, 64'(done), 64'd0);
            end
        end
        e_hi = xhi;
        e_lo = xlo;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        A     = '0;
        B     = '0;
        mt_hi = 1'b0;
        mt_lo = 1'b0;
        e_hi  = '0;
        e_lo  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(HI), 64'd0);
        chk("rst_lo", 64'(LO), 64'd0);
        rst = 1'b0;

        // MTHI alone, then MTHI+MTLO together
        A     = 32'h1234_5678;
        mt_hi = 1'b1;
        @(posedge clk); #1;
        mt_hi = 1'b0;
        chk("mthi_hi", 64'(HI), 64'h1234_5678);
        chk("mthi_lo", 64'(LO), 64'd0);
        A     = 32'hAAAA_5555;
        mt_hi = 1'b1;
        mt_lo = 1'b1;
        @(posedge clk); #1;
        mt_hi = 1'b0;
        mt_lo = 1'b0;
        chk("mtboth_hi", 64'(HI), 64'hAAAA_5555);
        chk("mtboth_lo", 64'(LO), 64'hAAAA_5555);
        e_hi = 32'hAAAA_5555;
        e_lo = 32'hAAAA_5555;

        // Multiply vectors
        run_op("mult_m1x2",   2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu_m1x2",  2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("mult_min2",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("mult_7xm3",   2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_big",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

`ifdef MULDIV_DIV_EN
        run_op("div_m7d2",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_100d0",  2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF);
        run_op("div_m7d0",    2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_big",    2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);
        run_op("div_7dm2",    2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
`else
        // Divide without the divider: straight to FIN, HI/LO untouched
        op    = 2'b11;
        A     = 32'd10;
        B     = 32'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("nodiv_done", 64'(done), 64'd1);
        chk("nodiv_busy", 64'(busy), 64'd1);
        chk("nodiv_hi", 64'(HI), 64'(e_hi));
        chk("nodiv_lo", 64'(LO), 64'(e_lo));
        @(posedge clk); #1;
        chk("nodiv_idle_done", 64'(done), 64'd0);
        chk("nodiv_idle_busy", 64'(busy), 64'd0);
`endif

        // Abort a multiply with reset mid-operation
        op    = 2'b01;
        A     = 32'd3;
        B     = 32'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hi", 64'(HI), 64'd0);
        chk("abort_lo", 64'(LO), 64'd0);
        @(posedge clk); #1;
        rst  = 1'b0;
        e_hi = '0;
        e_lo = '0;
        run_op("multu_3x5", 2'b01, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
